// File: rtl/mpsoc_irq_ctrl.sv
// Avalon-MM interrupt controller: per-source sync, edge/level capture, pending/enable
// masking, lowest-index-wins priority, acknowledge, software trigger and overrun flags.
module mpsoc_irq_ctrl #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] EDGE_MASK   = 16'h0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq_out,
  output logic [3:0]         irq_id
);

  localparam logic [NUM_IRQ-1:0] EDGE_BITS = EDGE_MASK[NUM_IRQ-1:0];

  // Bus protocol: a write is chipselect && !write_n, taken on that clock edge with no
  // wait states; readdata always shows the register addressed in the previous cycle.
  logic               wr_en;
  logic [NUM_IRQ-1:0] wd;

  logic [NUM_IRQ-1:0] sync_s;
  logic [NUM_IRQ-1:0] s_q;
  logic [NUM_IRQ-1:0] edge_det;

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] overrun_q, overrun_d;
  logic [NUM_IRQ-1:0] soft_hold_q, soft_hold_d;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_out_q;
  logic [3:0]         irq_id_q;

  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] act_oh;
  logic [3:0]         act_id;
  logic               act_valid;

  logic [NUM_IRQ-1:0] w1c_pend, w1c_ovr, soft_set, ack_clr;
  logic [NUM_IRQ-1:0] edge_pend, level_pend;

  assign wr_en = chipselect & ~write_n;
  assign wd    = writedata[NUM_IRQ-1:0];

  generate
    if (NUM_IRQ < 16) begin : g_unused_wd
      logic unused_wd;
      assign unused_wd = ^writedata[15:NUM_IRQ];
    end

    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_s = irq_in;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= irq_in;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sync_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign edge_det = sync_s & ~s_q;
  assign active   = pending_q & enable_q;

  // Scan high to low so the lowest set index is the one left standing.
  always_comb begin
    act_id = '0;
    act_oh = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        act_id    = 4'(i);
        act_oh    = '0;
        act_oh[i] = 1'b1;
      end
    end
  end
  assign act_valid = |active;

  assign w1c_pend = (wr_en && address == 3'd1) ? wd : '0;
  assign w1c_ovr  = (wr_en && address == 3'd7) ? wd : '0;
  assign soft_set = (wr_en && address == 3'd6) ? wd : '0;
  assign ack_clr  = (wr_en && address == 3'd5) ? (act_oh & EDGE_BITS) : '0;

  // Edge bits: new edges and soft sets win over a same-cycle clear.
  assign edge_pend   = (pending_q & ~(w1c_pend | ack_clr)) | edge_det | soft_set;
  assign soft_hold_d = ((soft_hold_q & ~w1c_pend) | soft_set) & ~EDGE_BITS;
  assign level_pend  = sync_s | soft_hold_d;
  assign pending_d   = (EDGE_BITS & edge_pend) | (~EDGE_BITS & level_pend);
  assign overrun_d   = (overrun_q & ~w1c_ovr) | (edge_det & pending_q & EDGE_BITS);

  always_comb begin
    enable_d = enable_q;
    if (wr_en) begin
      case (address)
        3'd2:    enable_d = wd;
        3'd3:    enable_d = enable_q | wd;
        3'd4:    enable_d = enable_q & ~wd;
        default: enable_d = enable_q;
      endcase
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0:    readdata_d = 16'(pending_q & enable_q);
      3'd1:    readdata_d = 16'(pending_q);
      3'd2,
      3'd3,
      3'd4:    readdata_d = 16'(enable_q);
      3'd5:    readdata_d = {act_valid, 11'b0, act_id};
      3'd6:    readdata_d = '0;
      default: readdata_d = 16'(overrun_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q         <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      overrun_q   <= '0;
      soft_hold_q <= '0;
      readdata_q  <= '0;
      irq_out_q   <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      s_q         <= sync_s;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      overrun_q   <= overrun_d;
      soft_hold_q <= soft_hold_d;
      readdata_q  <= readdata_d;
      irq_out_q   <= act_valid;
      irq_id_q    <= act_id;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;
  assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_mpsoc_irq_ctrl.sv
// Directed bench for mpsoc_irq_ctrl: source 0 is level, sources 1..7 are edge, two sync stages.
module tb_mpsoc_irq_ctrl;

  localparam int NUM_IRQ = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               chipselect = 1'b0;
  logic [2:0]         address = '0;
  logic               write_n = 1'b1;
  logic [15:0]        writedata = '0;
  logic [NUM_IRQ-1:0] irq_in = '0;
  logic [15:0]        readdata;
  logic               irq_out;
  logic [3:0]         irq_id;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rd;

  mpsoc_irq_ctrl #(
    .NUM_IRQ    (NUM_IRQ),
    .EDGE_MASK  (16'h00FE),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .irq_in    (irq_in),
    .readdata  (readdata),
    .irq_out   (irq_out),
    .irq_id    (irq_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
  endtask

  // driver tasks: all start and end on a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_IRQ-1:0] m);
    irq_in = irq_in | m;
    tick(1);
    irq_in = irq_in & ~m;
  endtask

  initial begin
    // reset state
    tick(2);
    check_eq("rst_irq_out", 16'(irq_out), 16'h0000);
    check_eq("rst_irq_id", 16'(irq_id), 16'h0000);
    check_eq("rst_readdata", readdata, 16'h0000);
    reset_n = 1'b1;
    tick(1);

    // enable register family, upper bits ignored
    bus_write(3'd2, 16'hFF03);
    bus_read(3'd2, rd);   check_eq("enable_rw", rd, 16'h0003);
    bus_write(3'd3, 16'h0010);
    bus_read(3'd4, rd);   check_eq("enable_set", rd, 16'h0013);
    bus_write(3'd4, 16'h0001);
    bus_read(3'd3, rd);   check_eq("enable_clr", rd, 16'h0012);

    // level source 0: 4-edge rise and fall latency
    bus_write(3'd2, 16'h0001);
    irq_in[0] = 1'b1;
    tick(3);              check_eq("lvl_rise_early", 16'(irq_out), 16'h0000);
    tick(1);              check_eq("lvl_rise", 16'(irq_out), 16'h0001);
    bus_read(3'd5, rd);   check_eq("lvl_active", rd, 16'h8000);
    bus_read(3'd0, rd);   check_eq("lvl_status", rd, 16'h0001);
    bus_write(3'd1, 16'h0001);
    bus_read(3'd1, rd);   check_eq("lvl_w1c_held", rd, 16'h0001);
    irq_in[0] = 1'b0;
    tick(3);              check_eq("lvl_fall_early", 16'(irq_out), 16'h0001);
    tick(1);              check_eq("lvl_fall", 16'(irq_out), 16'h0000);

    // edge sources 5 and 2 together, acked in priority order
    bus_write(3'd2, 16'h00FF);
    pulse(8'h24);
    tick(4);
    check_eq("edge_irq_out", 16'(irq_out), 16'h0001);
    check_eq("edge_irq_id", 16'(irq_id), 16'h0002);
    exp_q.push_back(16'h8002);
    exp_q.push_back(16'h8005);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 3; i++) begin
      bus_read(3'd5, rd);
      check_eq("ack_seq", rd, exp_q.pop_front());
      if (i < 2) bus_write(3'd5, 16'h0000);
    end
    check_eq("ack_irq_out", 16'(irq_out), 16'h0000);
    check_eq("ack_irq_id", 16'(irq_id), 16'h0000);

    // overrun on source 3
    pulse(8'h08);
    tick(4);
    pulse(8'h08);
    tick(4);
    bus_read(3'd7, rd);   check_eq("ovr_set", rd, 16'h0008);
    check_eq("ovr_irq_id", 16'(irq_id), 16'h0003);
    bus_write(3'd7, 16'h0008);
    bus_read(3'd7, rd);   check_eq("ovr_w1c", rd, 16'h0000);
    bus_read(3'd1, rd);   check_eq("ovr_pend_kept", rd, 16'h0008);
    bus_write(3'd1, 16'h0008);
    bus_read(3'd1, rd);   check_eq("pend_w1c", rd, 16'h0000);

    // W1C on bit 4 lands on the same edge as its synced edge
    pulse(8'h10);
    tick(1);
    bus_write(3'd1, 16'h0010);
    bus_read(3'd1, rd);   check_eq("set_beats_clr", rd, 16'h0010);
    bus_read(3'd7, rd);   check_eq("no_ovr_first", rd, 16'h0000);
    bus_write(3'd1, 16'h0010);
    bus_read(3'd1, rd);   check_eq("pend4_clr", rd, 16'h0000);
    check_eq("pend4_irq_out", 16'(irq_out), 16'h0000);

    // ack on source 7 coinciding with a new edge on it
    pulse(8'h80);
    tick(4);
    pulse(8'h80);
    tick(1);
    bus_write(3'd5, 16'h0000);
    bus_read(3'd1, rd);   check_eq("ack_edge_pend", rd, 16'h0080);
    bus_read(3'd7, rd);   check_eq("ack_edge_ovr", rd, 16'h0080);
    bus_write(3'd7, 16'h0080);
    bus_write(3'd1, 16'h0080);

    // software trigger while disabled, then enable via ENABLE_SET
    bus_write(3'd2, 16'h0000);
    bus_write(3'd6, 16'h0040);
    bus_read(3'd1, rd);   check_eq("soft_pend", rd, 16'h0040);
    check_eq("soft_irq_off", 16'(irq_out), 16'h0000);
    bus_read(3'd6, rd);   check_eq("soft_reads0", rd, 16'h0000);
    bus_write(3'd3, 16'h0040);
    check_eq("en_set_early", 16'(irq_out), 16'h0000);
    tick(1);
    check_eq("en_set_irq", 16'(irq_out), 16'h0001);
    check_eq("en_set_id", 16'(irq_id), 16'h0006);

    // sticky soft set on level source 0, cleared only by W1C
    bus_write(3'd6, 16'h0001);
    bus_read(3'd1, rd);   check_eq("soft_lvl_pend", rd, 16'h0041);
    tick(3);
    bus_read(3'd1, rd);   check_eq("soft_lvl_sticky", rd, 16'h0041);
    bus_write(3'd3, 16'h0001);
    tick(1);
    check_eq("soft_lvl_id", 16'(irq_id), 16'h0000);
    bus_write(3'd1, 16'h0001);
    bus_read(3'd1, rd);   check_eq("soft_lvl_w1c", rd, 16'h0040);
    check_eq("soft_lvl_id6", 16'(irq_id), 16'h0006);

    // async reset while the interrupt is asserted
    address = 3'd2;
    tick(1);
    check_eq("pre_rst_rd", readdata, 16'h0041);
    check_eq("pre_rst_irq", 16'(irq_out), 16'h0001);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_irq", 16'(irq_out), 16'h0000);
    check_eq("mid_rst_id", 16'(irq_id), 16'h0000);
    check_eq("mid_rst_rd", readdata, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1);
    bus_read(3'd2, rd);   check_eq("post_rst_enable", rd, 16'h0000);
    bus_read(3'd1, rd);   check_eq("post_rst_pend", rd, 16'h0000);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
